// File: rtl/serial_resp_pkg.sv
// Shared definitions for the DL11-style serial console responder:
// register indices, CSR bit positions, default address and vectors.
package bk_serial_pkg;

    typedef enum logic [1:0] {
        REG_RCSR = 2'd0,
        REG_RBUF = 2'd1,
        REG_XCSR = 2'd2,
        REG_XBUF = 2'd3
    } reg_idx_e;

    localparam int BIT_DONE = 7;
    localparam int BIT_IE   = 6;

    localparam logic [15:0] DEF_BASE_ADDR = 16'o177560;
    localparam logic [15:0] DEF_RX_VEC    = 16'o000060;
    localparam logic [15:0] DEF_TX_VEC    = 16'o000064;

    // Both CSRs share the layout: status flag in bit 7, interrupt enable in bit 6.
    function automatic logic [15:0] csr_word(input logic flag, input logic ie);
        logic [15:0] w;
        w           = '0;
        w[BIT_DONE] = flag;
        w[BIT_IE]   = ie;
        return w;
    endfunction

endpackage

// File: rtl/serial_resp_if.sv
// VM1 bus slice seen by the serial responder: address/data phase, strobes,
// bus clock enable, and the responder's read data and reply.
interface serial_resp_if;
    logic        ce;
    logic [15:0] bus_addr;
    logic [15:0] bus_din;
    logic        bus_sync;
    logic        bus_we;
    logic [1:0]  bus_wtbt;
    logic        bus_stb;
    logic [15:0] bus_dout;
    logic        bus_ack;

    modport master (
        output ce, bus_addr, bus_din, bus_sync, bus_we, bus_wtbt, bus_stb,
        input  bus_dout, bus_ack
    );

    modport slave (
        input  ce, bus_addr, bus_din, bus_sync, bus_we, bus_wtbt, bus_stb,
        output bus_dout, bus_ack
    );
endinterface

// File: rtl/serial_resp_irq_req.sv
// Interrupt request latch: sets on a rising edge of the request condition,
// clears on acknowledge or when the condition goes away.
module serial_irq_req (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic cond_i,
    input  logic iack_i,
    output logic req_o
);

    logic cond_q;
    logic req_q, req_d;

    always_comb begin
        req_d = req_q;
        if (cond_i && !cond_q) begin
            req_d = 1'b1;
        end else if (iack_i || !cond_i) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cond_q <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            cond_q <= cond_i;
            req_q  <= req_d;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/serial_resp.sv
// DL11-style serial console responder (RCSR/RBUF/XCSR/XBUF) on the VM1 bus.
// Define SERIAL_IRQ_EN to build the RIE/TIE bits and the interrupt requests.
module serial_resp
    import bk_serial_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [15:0] RX_VEC    = DEF_RX_VEC,
    parameter logic [15:0] TX_VEC    = DEF_TX_VEC
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    serial_resp_if.slave  bus,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ireq_rx,
    output logic          ireq_tx,
    input  logic          iack_rx,
    input  logic          iack_tx
);

    logic     sel, acc, start, rd_start, wr_lo, rbuf_clr, accept;
    reg_idx_e idx;
    logic     rie, tie;
    logic     unused_ok;

    logic        acc_q;
    logic        ack_q, ack_d;
    logic        pend_q, pend_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        outv_q, outv_d;
    logic        in_ready_q;
    logic [7:0]  rbuf_q, rbuf_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [15:0] rdata, rdata_q;

    assign sel      = bus.bus_sync && (bus.bus_addr[15:3] == BASE_ADDR[15:3]);
    assign acc      = sel && bus.bus_stb;
    assign start    = acc && !acc_q;
    assign idx      = reg_idx_e'(bus.bus_addr[2:1]);
    assign rd_start = start && !bus.bus_we;
    assign wr_lo    = start && bus.bus_we && bus.bus_wtbt[0];
    assign rbuf_clr = rd_start && (idx == REG_RBUF);
    // A CPU read of RBUF takes precedence over a byte arriving in the same cycle.
    assign accept   = in_valid && in_ready_q && !rbuf_clr;

    always_comb begin
        rdata = '0;
        case (idx)
            REG_RCSR: rdata = csr_word(done_q, rie);
            REG_RBUF: rdata = {8'h00, rbuf_q};
            REG_XCSR: rdata = csr_word(ready_q, tie);
            default:  rdata = '0;
        endcase
    end

    // Read data is captured at access start so later receive activity cannot
    // alter the word the CPU is still sampling.
    assign bus.bus_dout = (acc && !bus.bus_we) ? (start ? rdata : rdata_q) : '0;
    assign bus.bus_ack  = ack_q;

    always_comb begin
        done_d     = done_q;
        rbuf_d     = rbuf_q;
        ready_d    = ready_q;
        outv_d     = outv_q;
        out_data_d = out_data_q;
        ack_d      = ack_q;
        pend_d     = pend_q;

        if (rbuf_clr) begin
            done_d = 1'b0;
        end else if (accept) begin
            done_d = 1'b1;
            rbuf_d = in_data;
        end

        if (outv_q && out_ready) begin
            outv_d  = 1'b0;
            ready_d = 1'b1;
        end
        if (wr_lo && (idx == REG_XBUF) && ready_q) begin
            out_data_d = bus.bus_din[7:0];
            outv_d     = 1'b1;
            ready_d    = 1'b0;
        end

        if (!bus.bus_stb) begin
            ack_d  = 1'b0;
            pend_d = 1'b0;
        end else if (start || pend_q) begin
            if (bus.ce) begin
                ack_d  = 1'b1;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            acc_q      <= 1'b0;
            ack_q      <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            outv_q     <= 1'b0;
            in_ready_q <= 1'b0;
            rbuf_q     <= '0;
        end else begin
            acc_q      <= acc;
            ack_q      <= ack_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            outv_q     <= outv_d;
            in_ready_q <= !done_d;
            rbuf_q     <= rbuf_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        out_data_q <= out_data_d;
        if (start) begin
            rdata_q <= rdata;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = outv_q;

`ifdef SERIAL_IRQ_EN
    logic rie_q, tie_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rie_q <= 1'b0;
            tie_q <= 1'b0;
        end else if (wr_lo) begin
            if (idx == REG_RCSR) rie_q <= bus.bus_din[BIT_IE];
            if (idx == REG_XCSR) tie_q <= bus.bus_din[BIT_IE];
        end
    end

    assign rie = rie_q;
    assign tie = tie_q;

    serial_irq_req u_irq_rx (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .cond_i  (rie_q && done_q),
        .iack_i  (iack_rx),
        .req_o   (ireq_rx)
    );

    serial_irq_req u_irq_tx (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .cond_i  (tie_q && ready_q),
        .iack_i  (iack_tx),
        .req_o   (ireq_tx)
    );

    assign unused_ok = ^{bus.bus_din, bus.bus_addr[0], bus.bus_wtbt[1], RX_VEC, TX_VEC};
`else
    assign rie     = 1'b0;
    assign tie     = 1'b0;
    assign ireq_rx = 1'b0;
    assign ireq_tx = 1'b0;

    assign unused_ok = ^{bus.bus_din, bus.bus_addr[0], bus.bus_wtbt[1], RX_VEC, TX_VEC,
                         iack_rx, iack_tx};
`endif

endmodule

// File: tb/tb_serial_resp.sv
// Randomized scoreboard bench for serial_resp: a register-level model predicts
// read data, stream and interrupt behaviour; a monitor checks every read reply.
module tb_serial_resp;
    import bk_serial_pkg::*;

    localparam logic [15:0] BASE = 16'o177560;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic       ireq_rx, ireq_tx, iack_rx, iack_tx;

    serial_resp_if bus ();

    serial_resp dut (
        .clk_sys   (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ireq_rx   (ireq_rx),
        .ireq_tx   (ireq_tx),
        .iack_rx   (iack_rx),
        .iack_tx   (iack_tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the register file and streams
    bit         m_done = 0, m_ready = 1, m_rie = 0, m_tie = 0, m_outv = 0;
    logic [7:0] m_rbuf = 8'h00, m_out = 8'h00;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return (16'(m_done) << 7) | (16'(m_rie) << 6);
            2'd1:    return {8'h00, m_rbuf};
            2'd2:    return (16'(m_ready) << 7) | (16'(m_tie) << 6);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void model_reset();
        m_done = 0; m_ready = 1; m_rie = 0; m_tie = 0; m_outv = 0; m_rbuf = 8'h00;
    endfunction

    // Monitor: every rising reply on a read cycle consumes one expected word
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.bus_ack && !ack_prev && !bus.bus_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got %h expected no reply", bus.bus_dout);
            end else begin
                check("read_data", bus.bus_dout, exp_q.pop_front());
            end
        end
        ack_prev <= bus.bus_ack;
    end

    initial begin
        bus.ce = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.ce = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic bus_cycle(input logic [15:0] addr, input logic we,
                             input logic [15:0] din, input logic [1:0] wtbt);
        int n = 0;
        @(posedge clk); #1;
        bus.bus_addr = addr; bus.bus_sync = 1'b1; bus.bus_we = we;
        bus.bus_din  = din;  bus.bus_wtbt = wtbt;
        @(posedge clk); #1;
        bus.bus_stb = 1'b1;
        while (!bus.bus_ack && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.bus_ack) check("ack_timeout", 16'(bus.bus_ack), 16'h1);
        @(posedge clk); #1;
        bus.bus_stb = 1'b0;
        @(posedge clk); #1;
        check("ack_release", 16'(bus.bus_ack), 16'h0);
        bus.bus_sync = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] idx);
        exp_q.push_back(model_read(idx));
        if (idx == 2'd1) m_done = 0;
        bus_cycle(BASE + 16'({idx, 1'b0}), 1'b0, 16'h0, 2'b11);
    endtask

    task automatic write_reg(input logic [1:0] idx, input logic [15:0] data, input logic [1:0] wtbt);
        if (wtbt[0]) begin
            case (idx)
`ifdef SERIAL_IRQ_EN
                2'd0: m_rie = data[6];
                2'd2: m_tie = data[6];
`endif
                2'd3: if (m_ready) begin
                    m_out = data[7:0]; m_outv = 1; m_ready = 0;
                end
                default: ;
            endcase
        end
        bus_cycle(BASE + 16'({idx, 1'b0}), 1'b1, data, wtbt);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 16'(in_ready), 16'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_done = 1; m_rbuf = b;
    endtask

    task automatic pulse_out();
        @(negedge clk);
        check("out_valid", 16'(out_valid), 16'(m_outv));
        if (m_outv) check("out_data", 16'(out_data), 16'(m_out));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (m_outv) begin
            m_outv = 0; m_ready = 1;
        end
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.bus_addr = '0; bus.bus_din = '0; bus.bus_sync = 1'b0;
        bus.bus_we = 1'b0; bus.bus_wtbt = 2'b00; bus.bus_stb = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        iack_rx = 1'b0; iack_tx = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 16'(bus.bus_ack), 16'h0);
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_in_ready", 16'(in_ready), 16'h0);
        check("rst_ireq", 16'({ireq_rx, ireq_tx}), 16'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", 16'(in_ready), 16'h1);

        // Idle register values
        read_reg(2'd2);
        read_reg(2'd0);

        // Receive path
        send_byte(8'h41);
        check("in_ready_drop", 16'(in_ready), 16'h0);
        read_reg(2'd0);
        read_reg(2'd1);
        check("in_ready_after_rbuf", 16'(in_ready), 16'h1);
        read_reg(2'd0);

        // Transmit path with a stalled sink
        write_reg(2'd3, 16'h005A, 2'b01);
        check("tx_valid", 16'(out_valid), 16'h1);
        check("tx_data", 16'(out_data), 16'h5A);
        read_reg(2'd2);
        write_reg(2'd3, 16'h0033, 2'b01);
        check("tx_drop_data", 16'(out_data), 16'h5A);
        pulse_out();
        read_reg(2'd2);
        check("tx_data_hold", 16'(out_data), 16'h5A);

        // Transmit interrupt
        write_reg(2'd2, 16'o000100, 2'b01);
`ifdef SERIAL_IRQ_EN
        check("ireq_tx_set", 16'(ireq_tx), 16'h1);
        @(posedge clk); #1 iack_tx = 1'b1;
        @(posedge clk); #1 iack_tx = 1'b0;
        check("ireq_tx_ack", 16'(ireq_tx), 16'h0);
        write_reg(2'd3, 16'h0020, 2'b01);
        pulse_out();
        @(posedge clk); #1;
        check("ireq_tx_reassert", 16'(ireq_tx), 16'h1);
        write_reg(2'd2, 16'h0000, 2'b01);
`else
        check("ireq_tx_off", 16'(ireq_tx), 16'h0);
`endif
        read_reg(2'd2);

        // RBUF read coincident with an arriving byte
        send_byte(8'h11);
        in_data = 8'h7E; in_valid = 1'b1;
        read_reg(2'd1);
        in_valid = 1'b0;
        m_done = 1; m_rbuf = 8'h7E;
        check("coincident_in_ready", 16'(in_ready), 16'h0);
        read_reg(2'd0);
        read_reg(2'd1);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [1:0] idx;
            idx = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: read_reg(idx);
                1: write_reg(idx, 16'($urandom), 2'($urandom_range(0, 3)));
                2: if (!m_done) send_byte(8'($urandom)); else read_reg(2'd1);
                default: pulse_out();
            endcase
        end
`ifndef SERIAL_IRQ_EN
        check("ireq_rx_off", 16'(ireq_rx), 16'h0);
`endif

        // Address outside the block: no reply, no data
        @(posedge clk); #1;
        bus.bus_addr = 16'o177570; bus.bus_sync = 1'b1; bus.bus_we = 1'b0;
        @(posedge clk); #1 bus.bus_stb = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("unsel_dout", bus.bus_dout, 16'h0);
        check("unsel_ack", 16'(bus.bus_ack), 16'h0);
        bus.bus_stb = 1'b0;
        @(posedge clk); #1 bus.bus_sync = 1'b0;

        // Reset with a pending byte and an active reply
        if (m_outv) pulse_out();
        write_reg(2'd3, 16'h0077, 2'b01);
        @(posedge clk); #1;
        bus.bus_addr = BASE; bus.bus_sync = 1'b1; bus.bus_we = 1'b1;
        bus.bus_din = 16'h0000; bus.bus_wtbt = 2'b01;
        @(posedge clk); #1 bus.bus_stb = 1'b1;
        begin
            int n = 0;
            while (!bus.bus_ack && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("pre_rst_ack", 16'(bus.bus_ack), 16'h1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_drop_ack", 16'(bus.bus_ack), 16'h0);
        check("rst_drop_out", 16'(out_valid), 16'h0);
        check("rst_cycle_in_ready", 16'(in_ready), 16'h0);
        bus.bus_stb = 1'b0; bus.bus_sync = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("in_ready_rerun", 16'(in_ready), 16'h1);
        read_reg(2'd2);
        read_reg(2'd0);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
